// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// FSM state encoding and the bit-counter width function.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Smallest r with 2**r >= n; sizes the bit counter as clog2(WIDTH+1).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used by the serial adder datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle, LSB first, through a single full adder.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             count
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW   = clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
   logic             c_q;
   logic [CW-1:0]    bit_cnt;
   logic             fa_s, fa_co;
   logic             accept, last_bit;

   full_adder u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (c_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign accept   = start && (state != ADD);
   assign last_bit = (state == ADD) && (bit_cnt == LAST);
   assign res_nxt  = {fa_s, res_q[WIDTH-1:1]};
   assign busy     = (state == ADD);
   assign done     = (state == FIN);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ADD;
         ADD:     if (bit_cnt == LAST) state_nxt = FIN;
         FIN:     state_nxt = start ? ADD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs only move on the final ADD cycle, so they hold between completions.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         res_q   <= '0;
         bit_cnt <= '0;
         sum     <= '0;
         count   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf     <= 1'b0;
`endif
      end else if (accept) begin
         a_q     <= in_1;
         b_q     <= in_2;
         c_q     <= cin;
         res_q   <= '0;
         bit_cnt <= '0;
      end else if (state == ADD) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         c_q     <= fa_co;
         res_q   <= res_nxt;
         bit_cnt <= bit_cnt + CW'(1);
         if (last_bit) begin
            sum   <= res_nxt;
            count <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            // c_q is the carry into the MSB cell, fa_co the carry out of it.
            ovf   <= c_q ^ fa_co;
`endif
         end
      end
   end

endmodule
